// File: rtl/ac_e_register.sv
// Accumulator (AC) and carry/extend flip-flop (E) sitting downstream of the ALU.
// Captures ALU result/carry and executes register-reference micro-ops
// (clear, complement E, increment, circulate through E). The skip flags
// are decoded from the registered state only, so there is no input-to-flag path.
//
// AC op priority : clr_ac > ld_ac > inr_ac > cir > cil > hold
// E  op priority : clr_e > cme > rotate carry (cir/cil winner) > ld_e > hold
module ac_e_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             ld_ac,
  input  logic             ld_e,
  input  logic             clr_ac,
  input  logic             inr_ac,
  input  logic             cir,
  input  logic             cil,
  input  logic             clr_e,
  input  logic             cme,
  output logic [WIDTH-1:0] out_ac,
  output logic             e_out,
  output logic             ac_zero,
  output logic             ac_neg,
  output logic             ac_pos,
  output logic             e_zero
);

  logic [WIDTH-1:0] ac_q;
  logic             e_q;
  logic [WIDTH-1:0] ac_d;
  logic             e_d;
  logic             cir_win;
  logic             cil_win;

  // Rotate ops only count when no higher-priority AC op claims the cycle;
  // a losing rotate must not disturb E.
  assign cir_win = cir & ~clr_ac & ~ld_ac & ~inr_ac;
  assign cil_win = cil & ~cir & ~clr_ac & ~ld_ac & ~inr_ac;

  // Next-state selection for AC and E, both from pre-edge AC/E values.
  always_comb begin
    ac_d = ac_q;
    if (clr_ac)       ac_d = '0;
    else if (ld_ac)   ac_d = alu_result;
    else if (inr_ac)  ac_d = ac_q + WIDTH'(1);
    else if (cir_win) ac_d = {e_q, ac_q[WIDTH-1:1]};
    else if (cil_win) ac_d = {ac_q[WIDTH-2:0], e_q};

    e_d = e_q;
    if (clr_e)        e_d = 1'b0;
    else if (cme)     e_d = ~e_q;
    else if (cir_win) e_d = ac_q[0];
    else if (cil_win) e_d = ac_q[WIDTH-1];
    else if (ld_e)    e_d = alu_cout;
  end

  // State register; reset overrides every control in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ac_q <= '0;
      e_q  <= 1'b0;
    end else begin
      ac_q <= ac_d;
      e_q  <= e_d;
    end
  end

  assign out_ac  = ac_q;
  assign e_out   = e_q;
  assign ac_zero = (ac_q == '0);
  assign ac_neg  = ac_q[WIDTH-1];
  assign ac_pos  = ~ac_q[WIDTH-1];
  assign e_zero  = ~e_q;

endmodule

// File: doc/ac_e_register.md
Name: ac_e_register

Overview:
- Accumulator (AC) and carry/extend flip-flop (E) for the basic accumulator computer. The block sits directly downstream of the ALU.
- It captures the ALU result and carry-out. It also executes the register-reference micro-ops: clear, complement E, increment, and circulate through E.
- It drives AC back to the ALU operand input and E to the ALU carry-in.
- It provides the skip-condition flags to the control unit.

Parameters:
WIDTH, 8, data width of AC; must match ALU operand width.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
alu_result  input  WIDTH  result bus from ALU
alu_cout  input  1  carry-out from ALU
ld_ac  input  1  load AC from alu_result
ld_e  input  1  load E from alu_cout (asserted by control on ADD only)
clr_ac  input  1  clear AC (CLA)
inr_ac  input  1  increment AC (INC)
cir  input  1  circulate {E,AC} right (CIR)
cil  input  1  circulate {E,AC} left (CIL)
clr_e  input  1  clear E (CLE)
cme  input  1  complement E (CME)
out_ac  output  WIDTH  current AC register value, to ALU
e_out  output  1  current E value, to ALU carry-in
ac_zero  output  1  AC == 0 (SZA)
ac_neg  output  1  AC[WIDTH-1] == 1 (SNA)
ac_pos  output  1  AC[WIDTH-1] == 0 (SPA; zero counts as positive)
e_zero  output  1  E == 0 (SZE)

Behaviour:
- Reset: synchronous, active-high, on the rising clk edge. AC <= 0 and E <= 0, so ac_zero=1, ac_pos=1, ac_neg=0, e_zero=1. Reset overrides every control input in the same cycle. A reset asserted mid-sequence discards the pending op; no partial update.
- Latency:
  - All ops take effect on the clock edge where the control is sampled high; the new value is visible on out_ac/e_out from the next cycle.
  - Flags are combinational from the registered AC/E only. They are never a function of the inputs, so there is no path from inputs to flags.
- AC update: a one-hot priority chain; exactly one op wins per cycle.
  - clr_ac: AC <= 0.
  - ld_ac: AC <= alu_result.
  - inr_ac: AC <= AC + 1, modulo 2^WIDTH. FF -> 00 wraps silently and E is NOT affected.
  - cir: AC <= {E, AC[WIDTH-1:1]}.
  - cil: AC <= {AC[WIDTH-2:0], E}.
  - none: AC holds.
- E update: evaluated independently, highest priority first.
  - clr_e: E <= 0.
  - cme: E <= ~E.
  - Winning AC op is cir: E <= AC[0] (old value).
  - Winning AC op is cil: E <= AC[WIDTH-1] (old value).
  - ld_e: E <= alu_cout.
  - otherwise: E holds.
- Circulate semantics: cir/cil use the pre-edge values of AC and E, so the rotation is a true WIDTH+1-bit rotate. cir and cil both high: cir wins, cil is ignored.
- Simultaneous events:
  - ld_ac with ld_e: AC and E load together (ADD case); this is the normal path.
  - clr_ac with cir: AC <= 0. E is not rotated because cir lost, so E holds unless an E control is active.
  - clr_e with cil: AC rotates using old E; E <= 0 (clr_e beats the rotate carry).
- Width rules: no sign extension anywhere. Increment and rotate are WIDTH-bit only; E is never touched by inr_ac.
- Inputs alu_result/alu_cout are sampled only when ld_ac/ld_e are high; X on them is otherwise harmless.

Test Plan:
- Reset: drive rst=1 for 1 cycle with ld_ac=1, alu_result=8'h5A -> AC=00, E=0, ac_zero=1, ac_pos=1, e_zero=1. Release rst -> values persist.
- ADD capture: ld_ac=1, ld_e=1, alu_result=8'h2C, alu_cout=1 -> next cycle out_ac=2C, e_out=1, ac_pos=1, e_zero=0. Hold all controls low 3 cycles -> unchanged.
- Increment wrap: AC=FF, E=1, inr_ac=1 -> AC=00, E=1 (unchanged), ac_zero=1. A second inr_ac -> AC=01.
- Circulate:
  - AC=81, E=0, cir=1 -> AC=40, E=1.
  - Then cil=1 -> AC=81, E=0.
  - Then cil=1 -> AC=02, E=1.
  - 9 consecutive cir from AC=81, E=0 -> AC=81, E=0 restored.
- Priority: AC=33, E=1.
  - clr_ac=1, ld_ac=1, cir=1 -> AC=00, E=1.
  - Then clr_e=1, cil=1 with AC=80 -> AC=01, E=0.
  - Then cme=1, ld_e=1, alu_cout=0 -> E=1.
- Flags / reset mid-op: AC=80 -> ac_neg=1, ac_pos=0. Assert rst together with inr_ac and cme -> AC=00, E=0, no increment/complement seen.
